// File: rtl/serial_add32_ctrl.sv
// Byte-serial 32-bit add/subtract controller: one 8-bit slice per cycle, LSB first.
// Define SERIAL_ADD_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags are tied low.
module serial_add32_ctrl #(
   parameter bit STICKY_DONE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sub,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic        busy,
   output logic        done,
   output logic [31:0] s,
   output logic        cout,
   output logic        ovf,
   output logic        zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  idx;
   logic        carry;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        done_q;
   logic        accept;
   logic        last;
   logic [8:0]  bsum;

   always_comb begin
      accept = start && (state != BUSY);
      last   = (state == BUSY) && (idx == 2'd3);
      bsum   = {1'b0, opa[7:0]} + {1'b0, opb[7:0]} + {8'd0, carry};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (idx == 2'd3) state_nxt = DONE;
         DONE:    state_nxt = start ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operands shift right one byte per slice so the adder always sees bits [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         carry <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         s     <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub | cin;
      end else if (state == BUSY) begin
         s[{idx, 3'b000} +: 8] <= bsum[7:0];
         carry <= bsum[8];
         opa   <= opa >> 8;
         opb   <= opb >> 8;
         idx   <= idx + 2'd1;
         if (last) cout <= bsum[8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            done_q <= 1'b0;
      else if (accept)       done_q <= 1'b0;
      else if (last)         done_q <= 1'b1;
      else if (!STICKY_DONE) done_q <= 1'b0;
   end

`ifdef SERIAL_ADD_FLAGS_EN
   // Carry into bit 31 is recovered from the top slice's sum bit and its two operand bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (last) begin
         ovf  <= (opa[7] ^ opb[7] ^ bsum[7]) ^ bsum[8];
         zero <= (bsum[7:0] == 8'd0) && (s[23:0] == 24'd0);
      end
   end
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

   assign busy = (state == BUSY);
   assign done = done_q;

endmodule

// File: tb/tb_serial_add32_ctrl.sv
// Directed self-checking bench for serial_add32_ctrl; runs pulse-done and sticky-done instances in lockstep.
module tb_serial_add32_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;

   logic        busy, done, cout, ovf, zero;
   logic [31:0] s;
   logic        busy_s, done_s, cout_s, ovf_s, zero_s;
   logic [31:0] s_s;

   int ntests = 0;
   int nfail  = 0;
   int done_cnt = 0;
   int cnt0;

`ifdef SERIAL_ADD_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   serial_add32_ctrl #(.STICKY_DONE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
   );

   serial_add32_ctrl #(.STICKY_DONE(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_s), .done(done_s), .s(s_s), .cout(cout_s), .ovf(ovf_s), .zero(zero_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) done_cnt <= done_cnt + int'(done);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive a start at the current negedge; return at the negedge of the first busy cycle.
   task automatic start_op(input logic [31:0] va, input logic [31:0] vb,
                           input logic vcin, input logic vsub);
      a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input string tag, input int exp_busy, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
      int n;
      n = 0;
      while (busy && n < 12) begin
         n++;
         @(negedge clk);
      end
      check({tag, " busy cycles"}, n, exp_busy);
      check({tag, " done"}, done, 1'b1);
      check({tag, " done sticky"}, done_s, 1'b1);
      check({tag, " s"}, s, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " ovf"}, ovf, eo & FLAGS);
      check({tag, " zero"}, zero, ez & FLAGS);
      check({tag, " s sticky"}, s_s, es);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset s", s, 32'h0);
      check("reset flags", {29'd0, cout, ovf, zero}, 32'h0);

      // First start coincides with reset release: must be honoured at the very next edge.
      @(negedge clk);
      rst_n = 1'b1;
      start_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      check("first start busy", busy, 1'b1);
      check("busy done low", done, 1'b0);
      wait_done("wrap", 4, 32'h0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("pulse done low", done, 1'b0);
      check("sticky done held", done_s, 1'b1);

      start_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      wait_done("ovf", 4, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);

      start_op(32'd5, 32'd7, 1'b0, 1'b1);
      wait_done("5-7", 4, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      start_op(32'd7, 32'd5, 1'b1, 1'b1);
      wait_done("7-5", 4, 32'h2, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Second start pulsed in busy cycle 2 must be dropped.
      cnt0 = done_cnt;
      start_op(32'h0000_00FF, 32'h1, 1'b1, 1'b0);
      @(negedge clk);
      a = 32'h1234_0000; b = 32'h0000_4321; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore", 2, 32'h0000_0101, 1'b0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      check("ignore done count", done_cnt - cnt0, 1);
      check("ignore idle", busy, 1'b0);

      // Reset in busy cycle 3 abandons the operation.
      start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      check("pre-reset busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 1'b0);
      check("midreset done", {done, done_s}, 32'h0);
      check("midreset s", s, 32'h0);
      check("midreset flags", {29'd0, cout, ovf, zero}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt0 = done_cnt;
      repeat (6) @(negedge clk);
      check("no done after reset", done_cnt - cnt0, 0);
      check("no done sticky", done_s, 1'b0);
      start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      wait_done("post-reset", 4, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Back-to-back start issued in the done cycle.
      start_op(32'd1, 32'd2, 1'b0, 1'b0);
      wait_done("b2b first", 4, 32'd3, 1'b0, 1'b0, 1'b0);
      start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      check("b2b sticky cleared", done_s, 1'b0);
      check("b2b pulse cleared", done, 1'b0);
      check("b2b busy", busy_s, 1'b1);
      wait_done("b2b second", 4, 32'h0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold done sticky", done_s, 1'b1);
         check("hold done pulse", done, 1'b0);
         check("hold s", s_s, 32'h0);
         check("hold cout", cout_s, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/serial_add32_ctrl.md
SERIAL_ADD32_CTRL -- requirements
Module: serial_add32_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL provide parameter STICKY_DONE, default 0: 0 = done is a one-cycle pulse; 1 = done holds high until the next accepted start.
REQ-003 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: request a new 32-bit add/subtract.
REQ-006 Port sub, input, 1: 0 = A+B+cin; 1 = A-B, computed as A+~B+1 with cin ignored.
REQ-007 Port a, input, 32: operand A. Port b, input, 32: operand B. Port cin, input, 1: carry-in.
REQ-008 Port busy, output, 1: high while an operation is in progress.
REQ-009 Port done, output, 1: result valid indication.
REQ-010 Port s, output, 32: sum. Port cout, output, 1: carry out of bit 31.
REQ-011 Port ovf, output, 1: signed overflow. Port zero, output, 1: s equals 0.

Function
REQ-012 The block SHALL compute the 32-bit result byte-serially, one 8-bit slice per cycle, LSB byte first, with a registered carry between slices.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE->BUSY on start.
- BUSY stays BUSY for exactly 4 cycles (byte index 0..3), then goes to DONE.
- DONE->BUSY on start, else DONE->IDLE.
REQ-014 A start sampled high in IDLE or DONE SHALL latch a, b (inverted when sub=1), sub and carry-in (1 when sub=1, else cin) at that edge; later changes on the inputs SHALL NOT affect the operation.
REQ-015 A start sampled while in BUSY SHALL be ignored, with no queuing.
REQ-016 busy SHALL be high exactly in the 4 BUSY cycles.
REQ-017 With start accepted at edge k, s[8i+7:8i] SHALL be written at edge k+1+i, and done SHALL rise after edge k+4.
REQ-018 Latency SHALL be 4 cycles, and throughput SHALL be one operation per 5 cycles, including back-to-back starts issued in DONE.
REQ-019 With STICKY_DONE=0, done SHALL be high for the single DONE cycle. With STICKY_DONE=1, done SHALL stay high through IDLE until the next accepted start, and SHALL clear at that start's edge.
REQ-020 s, cout, ovf and zero SHALL hold stable from done rising until the next accepted start.
REQ-021 While BUSY, s SHALL contain the partially updated result.
REQ-022 cout SHALL be the carry out of byte 3.
REQ-023 ovf SHALL be the carry into bit 31 XOR the carry out of bit 31.
REQ-024 zero SHALL be 1 when the completed s equals 32'h0.
REQ-025 Arithmetic SHALL be modulo 2^32 and wrap silently; cout reports the wrap.

Reset
REQ-026 rst_n low SHALL immediately force the following, regardless of clk: state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, zero=0, byte index 0, carry register 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation. No done SHALL follow.
REQ-028 The first start SHALL be honoured at the first rising edge after rst_n deasserts.

Configuration
REQ-029 The block SHALL support macro SERIAL_ADD_FLAGS_EN.
- Defined: ovf and zero SHALL be computed as in REQ-023 and REQ-024.
- Undefined: ovf and zero SHALL be constant 0, and their logic SHALL be absent.
- Ports SHALL exist in both cases.

Verification
REQ-030 Bench: a=32'hFFFF_FFFF, b=1, cin=0, sub=0, start one cycle -> busy high 4 cycles; done after 4 cycles; s=0, cout=1, zero=1, ovf=0.
REQ-031 Bench: a=32'h7FFF_FFFF, b=1, sub=0 -> s=32'h8000_0000, cout=0, ovf=1; with SERIAL_ADD_FLAGS_EN undefined -> ovf=0.
REQ-032 Bench: a=5, b=7, sub=1 -> s=32'hFFFF_FFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> s=2, cout=1.
REQ-033 Bench: a=32'h0000_00FF, b=1, cin=1, second start pulsed in BUSY cycle 2 -> second start ignored; s=32'h0000_0101; exactly one done.
REQ-034 Bench: rst_n pulsed low during BUSY cycle 3 -> all outputs 0 immediately; no done; a new start after release gives the correct result.
REQ-035 Bench: back-to-back starts in DONE with STICKY_DONE=1 -> done clears at the accepting edge; second result after 4 more cycles; operands changed after the start edge do not alter the result.
